// File: rtl/dmem_storebuf.sv
// Data memory for the MEM stage with an in-order store buffer.
// Stores land in a small circular buffer. The buffer drains into the
// single-ported array on load-free cycles. Loads see buffered bytes through
// byte-wise forwarding, and the youngest matching entry wins.
module dmem_storebuf #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SB_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               a_i,
  input  logic [XLEN-1:0]           wd_i,
  input  logic                      we_i,
  input  logic [3:0]                amp_i,
  input  logic                      re_i,
  output logic [XLEN-1:0]           rd_o,
  output logic                      stall_o,
  output logic [$clog2(SB_DEPTH):0] sb_count_o
);

  localparam int PW    = $clog2(SB_DEPTH);
  localparam int CW    = PW + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BW    = XLEN / 4;

  // Backing array: it is never reset, so its contents survive a reset.
  logic [XLEN-1:0]       r_mem [DEPTH];

  // Store-buffer entries and the circular-FIFO bookkeeping.
  logic [SB_DEPTH-1:0]   r_valid;
  logic [ADDR_WIDTH-1:0] r_ewidx [SB_DEPTH];
  logic [XLEN-1:0]       r_edata [SB_DEPTH];
  logic [3:0]            r_emask [SB_DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic [ADDR_WIDTH-1:0] w_widx;
  logic [2:0]            w_pop;
  logic [XLEN-1:0]       w_lane;
  logic [PW-1:0]         w_young;
  logic                  w_store;
  logic                  w_drain;
  logic                  w_coalesce;
  logic                  w_push;
  logic                  w_full;
  logic                  w_unused_abits;

  assign w_widx         = a_i[ADDR_WIDTH+1:2];
  assign w_unused_abits = ^{a_i[31:ADDR_WIDTH+2], a_i[1:0]};
  assign w_pop          = {2'b0, amp_i[0]} + {2'b0, amp_i[1]} + {2'b0, amp_i[2]} + {2'b0, amp_i[3]};
  assign w_young        = r_tail - PW'(1);
  assign w_store        = we_i & (amp_i != 4'b0);
  assign w_drain        = ~re_i & (r_count != '0);
  assign w_full         = (r_count == CW'(SB_DEPTH));

  // Replicate the low-justified store data across the byte lanes, chosen by access size.
  always_comb begin
    w_lane = wd_i;
    if (w_pop == 3'd1)      w_lane = {4{wd_i[BW-1:0]}};
    else if (w_pop == 3'd2) w_lane = {2{wd_i[2*BW-1:0]}};
  end

  // A store merges into the youngest entry only when the youngest entry is not also the head draining this cycle.
  assign w_coalesce = w_store & (r_count != '0) & (r_ewidx[w_young] == w_widx)
                    & ~(w_drain & (w_young == r_head));
  assign w_push     = w_store & ~stall_o & ~w_coalesce;
  assign stall_o    = w_store & ~w_coalesce & w_full;
  assign sb_count_o = r_count;

  // Buffer state: pop at head on drain, merge into youngest, or push at tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        r_ewidx[i] <= '0;
        r_edata[i] <= '0;
        r_emask[i] <= '0;
      end
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_coalesce) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (amp_i[k]) r_edata[w_young][k*BW +: BW] <= w_lane[k*BW +: BW];
        end
        r_emask[w_young] <= r_emask[w_young] | amp_i;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_ewidx[r_tail] <= w_widx;
        r_edata[r_tail] <= w_lane;
        r_emask[r_tail] <= amp_i;
        r_tail          <= r_tail + PW'(1);
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Commit the head entry into the array under its byte mask.
  always_ff @(posedge clk) begin
    if (w_drain) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (r_emask[r_head][k]) r_mem[r_ewidx[r_head]][k*BW +: BW] <= r_edata[r_head][k*BW +: BW];
      end
    end
  end

  // Load data: read the array word, then overlay matching entries from oldest to youngest.
  always_comb begin
    logic [PW-1:0] w_idx;
    rd_o = r_mem[w_widx];
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && r_valid[w_idx] && (r_ewidx[w_idx] == w_widx)) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (r_emask[w_idx][k]) rd_o[k*BW +: BW] = r_edata[w_idx][k*BW +: BW];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_storebuf.sv
// Testbench for dmem_storebuf: directed stimulus, scoreboard queue, and a separate negedge monitor.
module tb_dmem_storebuf;

  localparam int SEL_RD  = 0;
  localparam int SEL_STL = 1;
  localparam int SEL_CNT = 2;

  logic        clk;
  logic        reset;
  logic [31:0] a_i;
  logic [31:0] wd_i;
  logic        we_i;
  logic [3:0]  amp_i;
  logic        re_i;
  logic [31:0] rd_o;
  logic        stall_o;
  logic [2:0]  sb_count_o;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   failures;

  dmem_storebuf #(.XLEN(32), .ADDR_WIDTH(10), .SB_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_i        (a_i),
    .wd_i       (wd_i),
    .we_i       (we_i),
    .amp_i      (amp_i),
    .re_i       (re_i),
    .rd_o       (rd_o),
    .stall_o    (stall_o),
    .sb_count_o (sb_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      checks++;
      case (e.sel)
        SEL_RD:  act = rd_o;
        SEL_STL: act = {31'b0, stall_o};
        default: act = {29'b0, sb_count_o};
      endcase
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic [3:0] amp, input logic re);
    @(posedge clk);
    #1;
    a_i   = a;
    wd_i  = wd;
    we_i  = we;
    amp_i = amp;
    re_i  = re;
  endtask

  task automatic ex(input int sel, input logic [31:0] e, input string name);
    exp_t t;
    t.cyc  = cyc;
    t.sel  = sel;
    t.exp  = e;
    t.name = name;
    q.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    a_i      = '0;
    wd_i     = '0;
    we_i     = 1'b0;
    amp_i    = '0;
    re_i     = 1'b1;

    // Reset state
    step(32'h10, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 0, "rst_count"); ex(SEL_STL, 0, "rst_stall");
    step(32'h10, 32'h0, 1'b0, 4'h0, 1'b1);
    reset = 1'b0;

    // Test 1: word store, forward, drain
    step(32'h10, 32'h11223344, 1'b1, 4'hF, 1'b1);
    ex(SEL_STL, 0, "t1_sw_nostall"); ex(SEL_CNT, 0, "t1_cnt_before");
    step(32'h10, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_RD, 32'h11223344, "t1_fwd"); ex(SEL_CNT, 1, "t1_cnt1");
    step(32'h10, 32'h0, 1'b0, 4'h0, 1'b0);
    ex(SEL_RD, 32'h11223344, "t1_fwd_draining"); ex(SEL_CNT, 1, "t1_cnt_draining");
    step(32'h10, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 0, "t1_cnt_drained"); ex(SEL_RD, 32'h11223344, "t1_array");

    // Test 2: byte store to lane 3 over committed word
    step(32'h13, 32'h000000AB, 1'b1, 4'h8, 1'b1);
    step(32'h10, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_RD, 32'hAB223344, "t2_fwd"); ex(SEL_CNT, 1, "t2_cnt1");
    step(32'h10, 32'h0, 1'b0, 4'h0, 1'b0);
    ex(SEL_RD, 32'hAB223344, "t2_fwd_draining");
    step(32'h10, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 0, "t2_cnt_drained"); ex(SEL_RD, 32'hAB223344, "t2_array");

    // Test 3: two halfword stores coalesce
    step(32'h20, 32'h0000BEEF, 1'b1, 4'h3, 1'b1);
    step(32'h22, 32'h0000CAFE, 1'b1, 4'hC, 1'b1);
    ex(SEL_STL, 0, "t3_coalesce_nostall"); ex(SEL_CNT, 1, "t3_cnt_pre");
    step(32'h20, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 1, "t3_cnt_coalesced"); ex(SEL_RD, 32'hCAFEBEEF, "t3_fwd");
    step(32'h20, 32'h0, 1'b0, 4'h0, 1'b0);
    step(32'h20, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 0, "t3_cnt_drained"); ex(SEL_RD, 32'hCAFEBEEF, "t3_array");

    // Test 4: fill, no-op store, stall, push+drain (pointers wrap)
    step(32'h40, 32'h40404040, 1'b1, 4'hF, 1'b1);
    step(32'h44, 32'h44444444, 1'b1, 4'hF, 1'b1);
    step(32'h48, 32'h48484848, 1'b1, 4'hF, 1'b1);
    step(32'h4C, 32'h4C4C4C4C, 1'b1, 4'hF, 1'b1);
    ex(SEL_CNT, 3, "t4_cnt3");
    step(32'h50, 32'h0, 1'b1, 4'h0, 1'b1);
    ex(SEL_CNT, 4, "t4_full"); ex(SEL_STL, 0, "t4_amp0_nostall");
    step(32'h50, 32'h50505050, 1'b1, 4'hF, 1'b0);
    ex(SEL_STL, 1, "t4_stall"); ex(SEL_CNT, 4, "t4_cnt_stall");
    step(32'h50, 32'h50505050, 1'b1, 4'hF, 1'b0);
    ex(SEL_STL, 0, "t4_stall_clear"); ex(SEL_CNT, 3, "t4_cnt_after_stall");
    step(32'h50, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 3, "t4_cnt_pushdrain"); ex(SEL_RD, 32'h50505050, "t4_fwd50");
    step(32'h44, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_RD, 32'h44444444, "t4_array44");
    step(32'h4C, 32'h0, 1'b0, 4'h0, 1'b0);
    step(32'h4C, 32'h0, 1'b0, 4'h0, 1'b0);
    step(32'h4C, 32'h0, 1'b0, 4'h0, 1'b0);
    step(32'h4C, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 0, "t4_cnt_drained"); ex(SEL_RD, 32'h4C4C4C4C, "t4_array4c");

    // Test 5: youngest wins, no coalesce across an intervening entry
    step(32'h60, 32'hAAAAAAAA, 1'b1, 4'hF, 1'b1);
    step(32'h64, 32'h00000001, 1'b1, 4'hF, 1'b1);
    step(32'h60, 32'h00000055, 1'b1, 4'h1, 1'b1);
    ex(SEL_CNT, 2, "t5_cnt2");
    step(32'h60, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 3, "t5_cnt3"); ex(SEL_RD, 32'hAAAAAA55, "t5_fwd60");
    step(32'h64, 32'h0, 1'b0, 4'h0, 1'b0);
    ex(SEL_RD, 32'h00000001, "t5_fwd64");
    step(32'h60, 32'h0, 1'b0, 4'h0, 1'b0);
    step(32'h60, 32'h0, 1'b0, 4'h0, 1'b0);
    step(32'h60, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 0, "t5_cnt_drained"); ex(SEL_RD, 32'hAAAAAA55, "t5_array60");

    // Test 6: commit zero at 0x70, buffer stores, reset mid-stream
    step(32'h70, 32'h00000000, 1'b1, 4'hF, 1'b1);
    step(32'h70, 32'h0, 1'b0, 4'h0, 1'b0);
    step(32'h70, 32'h11111111, 1'b1, 4'hF, 1'b1);
    ex(SEL_CNT, 0, "t6_cnt_committed");
    step(32'h72, 32'h00002222, 1'b1, 4'hC, 1'b1);
    step(32'h70, 32'h00000033, 1'b1, 4'h1, 1'b1);
    step(32'h70, 32'h0, 1'b0, 4'h0, 1'b1);
    ex(SEL_CNT, 1, "t6_cnt_buffered"); ex(SEL_RD, 32'h22221133, "t6_fwd");
    step(32'h70, 32'h0, 1'b0, 4'h0, 1'b1);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    ex(SEL_CNT, 0, "t6_rst_cnt"); ex(SEL_STL, 0, "t6_rst_stall"); ex(SEL_RD, 32'h0, "t6_rst_rd");
    step(32'h70, 32'h0, 1'b0, 4'h0, 1'b0);
    ex(SEL_CNT, 0, "t6_post_cnt"); ex(SEL_RD, 32'h0, "t6_post_rd");

    step(32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
    repeat (2) @(posedge clk);
    #6;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
